sorted_insertion_queue: RTL and testbench

- Parametrised hardware-scheduler ready queue; next generation of the insertion block.
- Holds up to N task entries kept sorted by ascending key in a shift-register array; the head is the next task to dispatch.
- Adds a selectable key mode (EDF deadline / least laxity), a variable subtract amount, a full/overflow indication and an occupancy count.
- Deadline-miss tagging and purge during the repair period are retained.
- Sits between the task-release logic and the dispatcher.

---
 rtl/sched_pkg.sv | 27 ++
 rtl/sched_slot_cell.sv | 62 ++++++
 rtl/sorted_insertion_queue.sv | 162 ++++++++++++++++
 tb/tb_sorted_insertion_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared field layout and key arithmetic for the sorted ready queue.
// Functions work on 32-bit operands so any field width up to 32 bits can use them.
package sched_pkg;

    localparam int ID_W_DEF = 8;
    localparam int DL_W_DEF = 16;
    localparam int EX_W_DEF = 16;
    localparam int E_W_DEF  = ID_W_DEF + DL_W_DEF + EX_W_DEF + 1;

    // Entry layout, LSB first: flag, exec, deadline, id
    localparam int FLAG_OFS = 0;
    localparam int EX_OFS   = 1;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    function automatic logic [31:0] key_of(input logic [31:0] dl, input logic [31:0] ex,
                                           input logic mode);
        return mode ? sat_sub(dl, ex) : dl;
    endfunction

    function automatic logic miss(input logic [31:0] dl, input logic [31:0] ex);
        return (dl < ex) || (dl == 32'd0);
    endfunction

endpackage

// File: rtl/sched_slot_cell.sv
// One storage slot of the sorted queue: holds, ages, loads a new entry or a neighbour.
// Invalid slots are kept at zero so the head slot can drive data_out directly.
module sched_slot_cell
    import sched_pkg::*;
#(
    parameter int ID_W = ID_W_DEF,
    parameter int DL_W = DL_W_DEF,
    parameter int EX_W = EX_W_DEF,
    localparam int E_W = ID_W + DL_W + EX_W + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            own_vld_i,
    input  logic [E_W-1:0]  prev_e_i,
    input  logic            prev_vld_i,
    input  logic [E_W-1:0]  next_e_i,
    input  logic            next_vld_i,
    input  logic [E_W-1:0]  new_e_i,
    input  logic            ins_here_i,
    input  logic            shift_down_i,
    input  logic            shift_up_i,
    input  logic            age_i,
    input  logic [DL_W-1:0] sub_amt_i,
    output logic [E_W-1:0]  entry_o
);

    localparam int DL_LO = EX_OFS + EX_W;
    localparam int DL_HI = DL_LO + DL_W - 1;
    localparam int EX_HI = EX_OFS + EX_W - 1;

    logic [E_W-1:0]  entry_q, entry_d;
    logic [DL_W-1:0] dl_aged;

    always_comb begin
        dl_aged = DL_W'(sat_sub(32'(entry_q[DL_HI:DL_LO]), 32'(sub_amt_i)));
        entry_d = entry_q;
        if (age_i) begin
            if (own_vld_i) begin
                entry_d[DL_HI:DL_LO] = dl_aged;
                entry_d[FLAG_OFS]    = entry_q[FLAG_OFS] |
                                       miss(32'(dl_aged), 32'(entry_q[EX_HI:EX_OFS]));
            end
        end else if (ins_here_i) begin
            entry_d = new_e_i;
        end else if (shift_down_i) begin
            entry_d = prev_vld_i ? prev_e_i : '0;
        end else if (shift_up_i) begin
            entry_d = next_vld_i ? next_e_i : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/sorted_insertion_queue.sv
// Ready queue kept sorted by ascending key (deadline or laxity); head is next to dispatch.
// Supports aging by a variable amount, miss tagging, purge of tagged entries, and overflow.
module sorted_insertion_queue
    import sched_pkg::*;
#(
    parameter int ID_W = ID_W_DEF,
    parameter int DL_W = DL_W_DEF,
    parameter int EX_W = EX_W_DEF,
    parameter int N    = 8,
    localparam int E_W = ID_W + DL_W + EX_W + 1,
    localparam int CW  = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [E_W-1:0]  data_in,
    input  logic            rd,
    input  logic            mode,
    input  logic            subtract,
    input  logic [DL_W-1:0] sub_amt,
    input  logic            repair_period,
    output logic [E_W-1:0]  data_out,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic            accept,
    output logic            overflow,
    output logic [E_W-1:0]  data_fail,
    output logic            fail
);

    localparam int DL_LO = EX_OFS + EX_W;
    localparam int DL_HI = DL_LO + DL_W - 1;
    localparam int EX_HI = EX_OFS + EX_W - 1;

    logic [E_W-1:0] ent [N];
    logic [N-1:0]   vld, gt, flg, ins_here, sh_dn, sh_up;
    logic [E_W-1:0] new_e, fail_e;
    logic [31:0]    new_key;
    logic [CW-1:0]  pos_ins, pos_rw, pos_fl;
    logic           any_fl, norm, do_pop, do_purge;

    logic [CW-1:0]  count_q, count_d;
    logic           mode_q, overflow_q, fail_q;
    logic [E_W-1:0] data_fail_q;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(N));
    assign new_e = data_in & ~E_W'(1);

    // Compare vector and lowest-index priority encoders
    always_comb begin
        new_key = key_of(32'(data_in[DL_HI:DL_LO]), 32'(data_in[EX_HI:EX_OFS]), mode_q);
        for (int j = 0; j < N; j++) begin
            vld[j] = (j < int'(count_q));
            gt[j]  = vld[j] &&
                     (key_of(32'(ent[j][DL_HI:DL_LO]), 32'(ent[j][EX_HI:EX_OFS]), mode_q) > new_key);
            flg[j] = vld[j] && ent[j][FLAG_OFS];
        end
        pos_ins = count_q;
        pos_rw  = count_q;
        pos_fl  = '0;
        fail_e  = '0;
        any_fl  = |flg;
        for (int j = N - 1; j >= 0; j--) begin
            if (gt[j]) pos_ins = CW'(j);
            if (gt[j] && j >= 1) pos_rw = CW'(j);
            if (flg[j]) begin
                pos_fl = CW'(j);
                fail_e = ent[j];
            end
        end
    end

    always_comb begin
        norm     = ~subtract & ~repair_period;
        accept   = wr & norm & (~full | rd);
        do_pop   = rd & norm & ~empty;
        do_purge = ~subtract & repair_period & any_fl;
        for (int i = 0; i < N; i++) begin
            ins_here[i] = 1'b0;
            sh_dn[i]    = 1'b0;
            sh_up[i]    = 1'b0;
            if (do_purge) begin
                sh_up[i] = (i >= int'(pos_fl));
            end else if (accept && do_pop) begin
                // Head leaves and the new entry lands one place above its sorted position
                sh_up[i]    = (i + 1 < int'(pos_rw));
                ins_here[i] = (i + 1 == int'(pos_rw));
            end else if (accept) begin
                ins_here[i] = (i == int'(pos_ins));
                sh_dn[i]    = (i > int'(pos_ins));
            end else if (do_pop) begin
                sh_up[i] = 1'b1;
            end
        end
        count_d = count_q;
        if (do_purge || (do_pop && !accept)) begin
            count_d = count_q - CW'(1);
        end else if (accept && !do_pop) begin
            count_d = count_q + CW'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        logic [E_W-1:0] prev_e, next_e;
        logic           prev_v, next_v;
        if (i == 0) begin : g_first
            assign prev_e = '0;
            assign prev_v = 1'b0;
        end else begin : g_mid
            assign prev_e = ent[i-1];
            assign prev_v = vld[i-1];
        end
        if (i == N - 1) begin : g_last
            assign next_e = '0;
            assign next_v = 1'b0;
        end else begin : g_body
            assign next_e = ent[i+1];
            assign next_v = vld[i+1];
        end
        sched_slot_cell #(.ID_W(ID_W), .DL_W(DL_W), .EX_W(EX_W)) u_cell (
            .clk          (clk),
            .rst          (rst),
            .own_vld_i    (vld[i]),
            .prev_e_i     (prev_e),
            .prev_vld_i   (prev_v),
            .next_e_i     (next_e),
            .next_vld_i   (next_v),
            .new_e_i      (new_e),
            .ins_here_i   (ins_here[i]),
            .shift_down_i (sh_dn[i]),
            .shift_up_i   (sh_up[i]),
            .age_i        (subtract),
            .sub_amt_i    (sub_amt),
            .entry_o      (ent[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            fail_q      <= 1'b0;
            data_fail_q <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= wr & norm & full & ~rd;
            fail_q     <= do_purge;
            if (do_purge) data_fail_q <= fail_e;
            if (count_q == '0) mode_q <= mode;
        end
    end

    assign data_out  = ent[0];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign fail      = fail_q;
    assign data_fail = data_fail_q;

endmodule

// File: tb/tb_sorted_insertion_queue.sv
// Bench for sorted_insertion_queue (N=4): directed vector table, random run
// against a queue-based reference model, and an asynchronous reset mid-fill.
module tb_sorted_insertion_queue;

    localparam int ID_W = 8;
    localparam int DL_W = 16;
    localparam int EX_W = 16;
    localparam int N    = 4;
    localparam int E_W  = ID_W + DL_W + EX_W + 1;
    localparam int CW   = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            wr, rd, mode, subtract, repair_period;
    logic [DL_W-1:0] sub_amt;
    logic [E_W-1:0]  data_in;
    logic [E_W-1:0]  data_out, data_fail;
    logic            empty, full, accept, overflow, fail;
    logic [CW-1:0]   count;

    sorted_insertion_queue #(.ID_W(ID_W), .DL_W(DL_W), .EX_W(EX_W), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr            (wr),
        .data_in       (data_in),
        .rd            (rd),
        .mode          (mode),
        .subtract      (subtract),
        .sub_amt       (sub_amt),
        .repair_period (repair_period),
        .data_out      (data_out),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .accept        (accept),
        .overflow      (overflow),
        .data_fail     (data_fail),
        .fail          (fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] dl;
        logic [15:0] ex;
        logic        fl;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    logic m_mode = 1'b0;
    ent_t m_df   = '0;
    logic m_fail = 1'b0;
    logic m_ovf  = 1'b0;
    logic m_acc  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int keyf(input ent_t e, input logic md);
        if (md) return (e.dl > e.ex) ? (int'(e.dl) - int'(e.ex)) : 0;
        return int'(e.dl);
    endfunction

    task automatic model_step(input int w, input int r, input int md, input int sb,
                              input int amt, input int rp, input int id, input int dl,
                              input int ex);
        logic was_empty;
        ent_t e;
        int   k, pos, nd;
        was_empty = (mq.size() == 0);
        m_fail = 1'b0;
        m_ovf  = 1'b0;
        m_acc  = 1'b0;
        if (sb != 0) begin
            for (int i = 0; i < mq.size(); i++) begin
                nd = (int'(mq[i].dl) > amt) ? int'(mq[i].dl) - amt : 0;
                mq[i].dl = 16'(nd);
                if (nd < int'(mq[i].ex) || nd == 0) mq[i].fl = 1'b1;
            end
        end else if (rp != 0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].fl) begin
                    m_df   = mq[i];
                    m_fail = 1'b1;
                    mq.delete(i);
                    break;
                end
            end
        end else begin
            m_acc = (w != 0) && (mq.size() < N || r != 0);
            if (w != 0 && !m_acc) m_ovf = 1'b1;
            if (r != 0 && mq.size() > 0) void'(mq.pop_front());
            if (m_acc) begin
                e   = '{id: 8'(id), dl: 16'(dl), ex: 16'(ex), fl: 1'b0};
                k   = keyf(e, m_mode);
                pos = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (keyf(mq[i], m_mode) > k) begin
                        pos = i;
                        break;
                    end
                end
                mq.insert(pos, e);
            end
        end
        if (was_empty) m_mode = md[0];
    endtask

    task automatic check_outputs();
        ent_t head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("data_out", 64'(data_out), 64'(head));
        chk("count", 64'(count), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == N));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("fail", 64'(fail), 64'(m_fail));
        chk("data_fail", 64'(data_fail), 64'(m_df));
    endtask

    logic last_acc;

    // Drives one cycle of inputs (just after a rising edge), checks accept before
    // the next edge and all outputs just after it.
    task automatic apply(input int w, input int r, input int md, input int sb, input int amt,
                         input int rp, input int id, input int dl, input int ex);
        wr            = w[0];
        rd            = r[0];
        mode          = md[0];
        subtract      = sb[0];
        sub_amt       = 16'(amt);
        repair_period = rp[0];
        data_in       = {8'(id), 16'(dl), 16'(ex), 1'($urandom_range(0, 1))};
        #2;
        model_step(w, r, md, sb, amt, rp, id, dl, ex);
        last_acc = accept;
        chk("accept", 64'(accept), 64'(m_acc));
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    typedef struct {
        int wr, rd, md, sb, amt, rp, id, dl, ex;
        int acc, hid, cnt, ovf, fl, cdf;
    } vec_t;

    vec_t tbl[26];
    localparam logic [E_W-1:0] DF_EXP = {8'd1, 16'd3, 16'd4, 1'b1};

    initial begin
        // wr rd md sb amt rp id dl ex | acc head_id count ovf fail check_data_fail
        tbl[0]  = '{1,0,0,0,0,0, 1, 6,4, 1,1,1,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0, 2, 7,4, 1,1,2,0,0,0};
        tbl[2]  = '{1,0,0,0,0,0, 3, 5,4, 1,3,3,0,0,0};
        tbl[3]  = '{1,0,0,0,0,0, 4, 5,4, 1,3,4,0,0,0};
        tbl[4]  = '{1,0,0,0,0,0, 5, 1,1, 0,3,4,1,0,0};
        tbl[5]  = '{0,0,0,0,0,0, 0, 0,0, 0,3,4,0,0,0};
        tbl[6]  = '{1,1,0,0,0,0, 5, 1,1, 1,5,4,0,0,0};
        tbl[7]  = '{0,1,0,0,0,0, 0, 0,0, 0,4,3,0,0,0};
        tbl[8]  = '{0,1,0,0,0,0, 0, 0,0, 0,1,2,0,0,0};
        tbl[9]  = '{0,1,0,0,0,0, 0, 0,0, 0,2,1,0,0,0};
        tbl[10] = '{0,1,0,0,0,0, 0, 0,0, 0,0,0,0,0,0};
        tbl[11] = '{0,1,0,0,0,0, 0, 0,0, 0,0,0,0,0,0};
        tbl[12] = '{1,0,0,0,0,0, 1, 6,4, 1,1,1,0,0,0};
        tbl[13] = '{1,0,0,0,0,0, 2, 9,4, 1,1,2,0,0,0};
        tbl[14] = '{0,0,0,1,3,0, 0, 0,0, 0,1,2,0,0,0};
        tbl[15] = '{0,0,0,0,0,1, 0, 0,0, 0,2,1,0,1,1};
        tbl[16] = '{0,0,0,0,0,1, 0, 0,0, 0,2,1,0,0,1};
        tbl[17] = '{1,0,0,1,1,0, 7, 1,1, 0,2,1,0,0,0};
        tbl[18] = '{0,1,0,0,0,1, 0, 0,0, 0,2,1,0,0,0};
        tbl[19] = '{0,1,0,0,0,0, 0, 0,0, 0,0,0,0,0,0};
        tbl[20] = '{1,0,1,0,0,0, 1,10,8, 1,1,1,0,0,0};
        tbl[21] = '{1,0,1,0,0,0, 2, 6,1, 1,1,2,0,0,0};
        tbl[22] = '{1,0,0,0,0,0, 3, 4,0, 1,1,3,0,0,0};
        tbl[23] = '{0,1,0,0,0,0, 0, 0,0, 0,3,2,0,0,0};
        tbl[24] = '{0,1,0,0,0,0, 0, 0,0, 0,2,1,0,0,0};
        tbl[25] = '{0,1,0,0,0,0, 0, 0,0, 0,0,0,0,0,0};

        rst = 1'b1;
        wr = 1'b0; rd = 1'b0; mode = 1'b0; subtract = 1'b0; repair_period = 1'b0;
        sub_amt = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].wr, tbl[i].rd, tbl[i].md, tbl[i].sb, tbl[i].amt, tbl[i].rp,
                  tbl[i].id, tbl[i].dl, tbl[i].ex);
            chk($sformatf("tbl%0d_accept", i), 64'(last_acc), 64'(tbl[i].acc));
            chk($sformatf("tbl%0d_head_id", i), 64'(data_out[E_W-1 -: ID_W]), 64'(tbl[i].hid));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
            chk($sformatf("tbl%0d_fail", i), 64'(fail), 64'(tbl[i].fl));
            if (tbl[i].cdf != 0) chk($sformatf("tbl%0d_data_fail", i), 64'(data_fail), 64'(DF_EXP));
        end

        // Randomised traffic with frequent ties, aging, and purge windows
        for (int c = 0; c < 3000; c++) begin
            int rw, rr, rs, rp;
            rw = int'($urandom_range(0, 99) < 55);
            rr = int'($urandom_range(0, 99) < 35);
            rs = int'($urandom_range(0, 99) < 8);
            rp = int'($urandom_range(0, 99) < 12);
            apply(rw, rr, int'($urandom_range(0, 1)), rs, int'($urandom_range(0, 6)), rp,
                  int'($urandom_range(1, 255)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 20)));
        end

        // Drain, then asynchronous reset between edges after three inserts
        for (int c = 0; c < N; c++) apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 11, 20, 2);
        apply(1, 0, 0, 0, 0, 0, 12, 10, 2);
        apply(1, 0, 0, 0, 0, 0, 13, 30, 2);
        wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_fail", 64'(fail), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        mq.delete();
        m_mode = 1'b0;
        m_df   = '0;
        m_fail = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1, 0, 0, 0, 0, 0, 9, 50, 1);
        chk("post_rst_head_id", 64'(data_out[E_W-1 -: ID_W]), 64'(9));
        chk("post_rst_count", 64'(count), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
